// File: rtl/alu_exec_pkg.sv
// Shared types and defaults for the ALU execute stage.
package alu_exec_pkg;

    localparam int unsigned DefaultDataW = 32;

    // Opcodes 9-15 are illegal and have no enumerator.
    typedef enum logic [3:0] {
        OpAdd = 4'd0,
        OpSub = 4'd1,
        OpAnd = 4'd2,
        OpOr  = 4'd3,
        OpXor = 4'd4,
        OpSlt = 4'd5,
        OpSll = 4'd6,
        OpSrl = 4'd7,
        OpMul = 4'd8
    } alu_op_e;

    typedef enum logic {
        StIdle,
        StMulBusy
    } exec_state_e;

endpackage

// File: rtl/alu_exec_stage_shift_add_multiplier.sv
// Iterative shift-add multiplier: one partial-product step per cycle while stepping.
// The low DATA_W bits of the product are presented combinationally on the last step
// so the caller can register them on the same edge the final step completes.
module shift_add_multiplier #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MUL_STEPS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_step,
    input  logic [DATA_W-1:0] i_multiplicand,
    input  logic [DATA_W-1:0] i_multiplier,
    output logic              o_done,
    output logic [DATA_W-1:0] o_product
);
    localparam int unsigned CntW = $clog2(MUL_STEPS + 1);

    logic [DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0] r_mplier;
    logic [DATA_W-1:0] r_acc;
    logic [CntW-1:0]   r_count;
    logic [DATA_W-1:0] w_acc_next;

    // Accumulator value after the current step; bits shifted past DATA_W are dropped.
    always_comb begin
        w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    end

    assign o_done    = i_step && (r_count == CntW'(MUL_STEPS - 1));
    assign o_product = w_acc_next;

    // Load operands on start, then shift multiplicand left / multiplier right each step.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
        end else if (i_start) begin
            r_mcand  <= i_multiplicand;
            r_mplier <= i_multiplier;
            r_acc    <= '0;
            r_count  <= '0;
        end else if (i_step) begin
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_acc    <= w_acc_next;
            r_count  <= r_count + CntW'(1);
        end
    end

endmodule

// File: rtl/alu_exec_stage.sv
// ALU execute stage: single-cycle ALU ops plus a multi-cycle shift-add MUL,
// with registered register-file write port, flags and illegal-opcode pulse.
module alu_exec_stage
    import alu_exec_pkg::*;
#(
    parameter int unsigned DATA_W    = DefaultDataW,
    parameter int unsigned MUL_STEPS = DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic [4:0]        dest_reg,
    input  logic              wb_en,
    output logic [4:0]        write_reg_num,
    output logic [DATA_W-1:0] write_data,
    output logic              reg_write,
    output logic              zero_flag,
    output logic              ovf_flag,
    output logic              illegal_op
);
    localparam int unsigned ShamtW = $clog2(DATA_W);

    exec_state_e       r_state;
    logic [4:0]        r_write_reg_num;
    logic [DATA_W-1:0] r_write_data;
    logic              r_reg_write;
    logic              r_zero_flag;
    logic              r_ovf_flag;
    logic              r_illegal_op;
    logic [4:0]        r_mul_dest;
    logic              r_mul_wb;

    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_diff;
    logic [DATA_W-1:0] w_alu_res;
    logic              w_alu_ovf;
    logic              w_is_mul;
    logic              w_is_legal;
    logic              w_accept;
    logic              w_mul_start;
    logic              w_mul_step;
    logic              w_mul_done;
    logic [DATA_W-1:0] w_mul_product;

    assign in_ready      = (r_state == StIdle);
    assign w_accept      = in_valid && in_ready;
    assign w_mul_start   = w_accept && w_is_mul;
    assign w_mul_step    = (r_state == StMulBusy);

    assign write_reg_num = r_write_reg_num;
    assign write_data    = r_write_data;
    assign reg_write     = r_reg_write;
    assign zero_flag     = r_zero_flag;
    assign ovf_flag      = r_ovf_flag;
    assign illegal_op    = r_illegal_op;

    // Single-cycle ALU result, overflow and opcode classification.
    always_comb begin
        w_sum      = src_a + src_b;
        w_diff     = src_a - src_b;
        w_alu_res  = '0;
        w_alu_ovf  = 1'b0;
        w_is_mul   = 1'b0;
        w_is_legal = 1'b1;
        case (op)
            OpAdd: begin
                w_alu_res = w_sum;
                w_alu_ovf = (src_a[DATA_W-1] == src_b[DATA_W-1]) &&
                            (w_sum[DATA_W-1] != src_a[DATA_W-1]);
            end
            OpSub: begin
                w_alu_res = w_diff;
                w_alu_ovf = (src_a[DATA_W-1] != src_b[DATA_W-1]) &&
                            (w_diff[DATA_W-1] != src_a[DATA_W-1]);
            end
            OpAnd: w_alu_res = src_a & src_b;
            OpOr:  w_alu_res = src_a | src_b;
            OpXor: w_alu_res = src_a ^ src_b;
            OpSlt: w_alu_res = {{(DATA_W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OpSll: w_alu_res = src_a << src_b[ShamtW-1:0];
            OpSrl: w_alu_res = src_a >> src_b[ShamtW-1:0];
            OpMul: w_is_mul = 1'b1;
            default: w_is_legal = 1'b0;
        endcase
    end

    shift_add_multiplier #(
        .DATA_W    (DATA_W),
        .MUL_STEPS (MUL_STEPS)
    ) u_mul (
        .clk            (clk),
        .rst            (rst),
        .i_start        (w_mul_start),
        .i_step         (w_mul_step),
        .i_multiplicand (src_a),
        .i_multiplier   (src_b),
        .o_done         (w_mul_done),
        .o_product      (w_mul_product)
    );

    // Control FSM and registered write-port / flag outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state         <= StIdle;
            r_write_reg_num <= '0;
            r_write_data    <= '0;
            r_reg_write     <= 1'b0;
            r_zero_flag     <= 1'b0;
            r_ovf_flag      <= 1'b0;
            r_illegal_op    <= 1'b0;
            r_mul_dest      <= '0;
            r_mul_wb        <= 1'b0;
        end else begin
            r_reg_write  <= 1'b0;
            r_illegal_op <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        if (w_is_mul) begin
                            r_state    <= StMulBusy;
                            r_mul_dest <= dest_reg;
                            r_mul_wb   <= wb_en;
                        end else if (w_is_legal) begin
                            r_write_data    <= w_alu_res;
                            r_write_reg_num <= dest_reg;
                            r_zero_flag     <= (w_alu_res == '0);
                            r_ovf_flag      <= w_alu_ovf;
                            r_reg_write     <= wb_en;
                        end else begin
                            // Illegal opcode leaves write port and flags untouched.
                            r_illegal_op <= 1'b1;
                        end
                    end
                end
                StMulBusy: begin
                    if (w_mul_done) begin
                        r_state         <= StIdle;
                        r_write_data    <= w_mul_product;
                        r_write_reg_num <= r_mul_dest;
                        r_zero_flag     <= (w_mul_product == '0);
                        r_ovf_flag      <= 1'b0;
                        r_reg_write     <= r_mul_wb;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: transaction-level reference model compared
// every cycle, plus directed vectors with hand-computed expected values.
module tb_alu_exec_stage;

    localparam int unsigned MulSteps = 32;
    localparam longint SMax = 64'sd2147483647;
    localparam longint SMin = -64'sd2147483648;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [4:0]  dest_reg;
    logic        wb_en;
    logic [4:0]  write_reg_num;
    logic [31:0] write_data;
    logic        reg_write;
    logic        zero_flag;
    logic        ovf_flag;
    logic        illegal_op;

    int n_checks = 0;
    int n_fail   = 0;

    alu_exec_stage #(
        .DATA_W    (32),
        .MUL_STEPS (MulSteps)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .op            (op),
        .src_a         (src_a),
        .src_b         (src_b),
        .dest_reg      (dest_reg),
        .wb_en         (wb_en),
        .write_reg_num (write_reg_num),
        .write_data    (write_data),
        .reg_write     (reg_write),
        .zero_flag     (zero_flag),
        .ovf_flag      (ovf_flag),
        .illegal_op    (illegal_op)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference arithmetic in wide signed/unsigned integers; returns {ovf, result}.
    function automatic logic [32:0] ref_alu(input logic [3:0] f_op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      r;
        logic [63:0] p;
        logic [31:0] res;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        r   = 0;
        p   = '0;
        res = '0;
        ovf = 1'b0;
        case (f_op)
            4'd0: begin r = sa + sb; res = r[31:0]; ovf = (r > SMax) || (r < SMin); end
            4'd1: begin r = sa - sb; res = r[31:0]; ovf = (r > SMax) || (r < SMin); end
            4'd2: res = a & b;
            4'd3: res = a | b;
            4'd4: res = a ^ b;
            4'd5: res = (sa < sb) ? 32'd1 : 32'd0;
            4'd6: res = a << b[4:0];
            4'd7: res = a >> b[4:0];
            4'd8: begin p = {32'b0, a} * {32'b0, b}; res = p[31:0]; end
            default: res = '0;
        endcase
        return {ovf, res};
    endfunction

    // Model state: expected DUT outputs after each rising edge.
    int          m_cycle = 0;
    bit          m_known = 1'b0;
    bit          m_busy  = 1'b0;
    int          m_done_at = 0;
    logic [31:0] m_pend_data;
    logic [4:0]  m_pend_reg;
    logic        m_pend_wb;
    logic [32:0] m_now;
    logic        exp_ready;
    logic        exp_rw;
    logic        exp_zero;
    logic        exp_ovf;
    logic        exp_ill;
    logic [31:0] exp_data;
    logic [4:0]  exp_reg;

    always_comb m_now = ref_alu(op, src_a, src_b);

    always @(posedge clk) begin
        m_cycle <= m_cycle + 1;
        if (!rst) begin
            m_known   <= 1'b1;
            m_busy    <= 1'b0;
            exp_ready <= 1'b1;
            exp_rw    <= 1'b0;
            exp_zero  <= 1'b0;
            exp_ovf   <= 1'b0;
            exp_ill   <= 1'b0;
            exp_data  <= '0;
            exp_reg   <= '0;
        end else begin
            exp_rw  <= 1'b0;
            exp_ill <= 1'b0;
            if (m_busy) begin
                if (m_cycle == m_done_at) begin
                    m_busy    <= 1'b0;
                    exp_ready <= 1'b1;
                    exp_data  <= m_pend_data;
                    exp_reg   <= m_pend_reg;
                    exp_zero  <= (m_pend_data == 32'd0);
                    exp_ovf   <= 1'b0;
                    exp_rw    <= m_pend_wb;
                end
            end else if (in_valid) begin
                if (op <= 4'd7) begin
                    exp_data <= m_now[31:0];
                    exp_reg  <= dest_reg;
                    exp_zero <= (m_now[31:0] == 32'd0);
                    exp_ovf  <= m_now[32];
                    exp_rw   <= wb_en;
                end else if (op == 4'd8) begin
                    m_busy      <= 1'b1;
                    exp_ready   <= 1'b0;
                    m_done_at   <= m_cycle + MulSteps;
                    m_pend_data <= m_now[31:0];
                    m_pend_reg  <= dest_reg;
                    m_pend_wb   <= wb_en;
                end else begin
                    exp_ill <= 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and compare every output against the model.
    task automatic tick();
        @(negedge clk);
        if (m_known) begin
            chk("model.in_ready", 32'(in_ready), 32'(exp_ready));
            chk("model.reg_write", 32'(reg_write), 32'(exp_rw));
            chk("model.write_data", write_data, exp_data);
            chk("model.write_reg_num", 32'(write_reg_num), 32'(exp_reg));
            chk("model.zero_flag", 32'(zero_flag), 32'(exp_zero));
            chk("model.ovf_flag", 32'(ovf_flag), 32'(exp_ovf));
            chk("model.illegal_op", 32'(illegal_op), 32'(exp_ill));
        end
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d, input logic w);
        op       = o;
        src_a    = a;
        src_b    = b;
        dest_reg = d;
        wb_en    = w;
        in_valid = 1'b1;
        tick();
    endtask

    // Drop valid and scramble operands so nothing relies on them being held.
    task automatic idle();
        in_valid = 1'b0;
        op       = 4'd0;
        src_a    = 32'hDEAD_BEEF;
        src_b    = 32'h1234_5678;
        dest_reg = 5'd31;
        wb_en    = 1'b1;
    endtask

    task automatic wait_ready(input int limit, output int cycles);
        cycles = 0;
        while (!in_ready && cycles < limit) begin
            tick();
            cycles++;
        end
        chk("wait_ready.timeout", 32'(in_ready), 32'd1);
    endtask

    // Directed single-cycle vectors: op, a, b, dest, wb_en, expected write_data.
    logic [3:0]  t_op   [9] = '{4'd2, 4'd3, 4'd4, 4'd1, 4'd0, 4'd6, 4'd7, 4'd5, 4'd0};
    logic [31:0] t_a    [9] = '{32'hF0F0F0F0, 32'hF0F0F0F0, 32'h12345678, 32'h80000000,
                               32'hFFFFFFFF, 32'h00000001, 32'hF0000000, 32'h00000001,
                               32'h80000000};
    logic [31:0] t_b    [9] = '{32'hFF00FF00, 32'h0F0F0000, 32'h12345678, 32'h00000001,
                               32'h00000001, 32'h00000021, 32'h00000004, 32'hFFFFFFFF,
                               32'h80000000};
    logic [4:0]  t_dst  [9] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd0, 5'd0, 5'd9, 5'd10, 5'd11};
    logic        t_wb   [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] t_exp  [9] = '{32'hF000F000, 32'hFFFFF0F0, 32'h00000000, 32'h7FFFFFFF,
                               32'h00000000, 32'h00000002, 32'h0F000000, 32'h00000000,
                               32'h00000000};

    initial begin
        int cycles;
        int stray;

        // Reset held with a valid operation presented: nothing may be accepted.
        rst      = 1'b0;
        in_valid = 1'b1;
        op       = 4'd0;
        src_a    = 32'd1;
        src_b    = 32'd2;
        dest_reg = 5'd9;
        wb_en    = 1'b1;
        repeat (3) tick();
        chk("rst.write_data", write_data, 32'd0);
        chk("rst.reg_write", 32'(reg_write), 32'd0);
        rst = 1'b1;
        idle();
        tick();
        chk("rst.ready_after_release", 32'(in_ready), 32'd1);
        chk("rst.no_accept", 32'(reg_write), 32'd0);

        // Signed overflow on ADD.
        issue(4'd0, 32'h7FFFFFFF, 32'h00000001, 5'd5, 1'b1);
        chk("add_ovf.reg_write", 32'(reg_write), 32'd1);
        chk("add_ovf.write_reg_num", 32'(write_reg_num), 32'd5);
        chk("add_ovf.write_data", write_data, 32'h80000000);
        chk("add_ovf.ovf_flag", 32'(ovf_flag), 32'd1);
        chk("add_ovf.zero_flag", 32'(zero_flag), 32'd0);

        // Back-to-back SUB then SLT.
        issue(4'd1, 32'd3, 32'd3, 5'd6, 1'b1);
        chk("sub_zero.write_data", write_data, 32'd0);
        chk("sub_zero.zero_flag", 32'(zero_flag), 32'd1);
        chk("sub_zero.reg_write", 32'(reg_write), 32'd1);
        issue(4'd5, 32'hFFFFFFFF, 32'd1, 5'd8, 1'b1);
        chk("slt.write_data", write_data, 32'd1);
        chk("slt.reg_write", 32'(reg_write), 32'd1);
        chk("slt.zero_flag", 32'(zero_flag), 32'd0);
        idle();
        tick();
        chk("slt.pulse_end", 32'(reg_write), 32'd0);

        // Back-to-back table of single-cycle ops.
        for (int i = 0; i < 9; i++) begin
            issue(t_op[i], t_a[i], t_b[i], t_dst[i], t_wb[i]);
            chk($sformatf("vec%0d.write_data", i), write_data, t_exp[i]);
            chk($sformatf("vec%0d.reg_write", i), 32'(reg_write), 32'(t_wb[i]));
        end
        chk("vec_sub_ovf.ovf_flag", 32'(ovf_flag), 32'd1);
        idle();
        tick();

        // Illegal opcode leaves write_data untouched.
        issue(4'd0, 32'd5, 32'd6, 5'd12, 1'b1);
        issue(4'd12, 32'd1, 32'd1, 5'd13, 1'b1);
        chk("illegal.illegal_op", 32'(illegal_op), 32'd1);
        chk("illegal.reg_write", 32'(reg_write), 32'd0);
        chk("illegal.write_data", write_data, 32'd11);
        chk("illegal.write_reg_num", 32'(write_reg_num), 32'd12);
        idle();
        tick();
        chk("illegal.pulse_end", 32'(illegal_op), 32'd0);

        // SRL is logical; wb_en=0 still updates data.
        issue(4'd7, 32'h80000000, 32'd31, 5'd14, 1'b0);
        chk("srl.write_data", write_data, 32'd1);
        chk("srl.reg_write", 32'(reg_write), 32'd0);
        idle();
        tick();

        // MUL with in_valid pulses while busy.
        issue(4'd8, 32'h00010001, 32'h00010001, 5'd7, 1'b1);
        chk("mul.ready_low", 32'(in_ready), 32'd0);
        cycles = 0;
        stray  = 0;
        while (!in_ready && cycles < 100) begin
            in_valid = cycles[0];
            op       = 4'd0;
            src_a    = 32'(cycles);
            src_b    = 32'd1;
            dest_reg = 5'd20;
            tick();
            cycles++;
            if (reg_write && !in_ready) stray++;
        end
        idle();
        chk("mul.busy_cycles", 32'(cycles), 32'd32);
        chk("mul.stray_writes", 32'(stray), 32'd0);
        chk("mul.reg_write", 32'(reg_write), 32'd1);
        chk("mul.write_data", write_data, 32'h00020001);
        chk("mul.write_reg_num", 32'(write_reg_num), 32'd7);
        tick();
        chk("mul.pulse_end", 32'(reg_write), 32'd0);

        // MUL wrap-around with wb_en=0.
        issue(4'd8, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd15, 1'b0);
        idle();
        wait_ready(100, cycles);
        chk("mul_wrap.write_data", write_data, 32'd1);
        chk("mul_wrap.reg_write", 32'(reg_write), 32'd0);
        tick();

        // Reset in the middle of a multiply aborts it.
        issue(4'd8, 32'd6, 32'd7, 5'd3, 1'b1);
        idle();
        repeat (10) tick();
        rst      = 1'b0;
        in_valid = 1'b1;
        repeat (2) tick();
        chk("mul_rst.write_data", write_data, 32'd0);
        chk("mul_rst.write_reg_num", 32'(write_reg_num), 32'd0);
        chk("mul_rst.reg_write", 32'(reg_write), 32'd0);
        rst = 1'b1;
        idle();
        tick();
        chk("mul_rst.ready", 32'(in_ready), 32'd1);
        repeat (40) tick();
        chk("mul_rst.no_late_write", 32'(write_data), 32'd0);

        issue(4'd0, 32'd2, 32'd3, 5'd1, 1'b1);
        chk("post_rst.write_data", write_data, 32'd5);
        idle();
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_exec_stage.md
ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width.
REQ-002 Parameter: MUL_STEPS, 32, shift-add iterations per MUL; equals DATA_W.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-low reset; sampled on rising clk only.
REQ-005 in_valid  in  1  decode presents an operation.
REQ-006 in_ready  out  1  stage can accept; operation accepted on edge where in_valid && in_ready.
REQ-007 op  in  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 SLL, 7 SRL, 8 MUL, 9-15 illegal.
REQ-008 src_a  in  DATA_W  first operand (register file read_data1).
REQ-009 src_b  in  DATA_W  second operand (register file read_data2).
REQ-010 dest_reg  in  5  destination register number.
REQ-011 wb_en  in  1  operation writes its result back.
REQ-012 write_reg_num  out  5  to register file write port.
REQ-013 write_data  out  DATA_W  to register file write port.
REQ-014 reg_write  out  1  one-cycle write strobe to register file.
REQ-015 zero_flag  out  1  registered: last result == 0.
REQ-016 ovf_flag  out  1  registered: signed overflow of last ADD/SUB, else 0.
REQ-017 illegal_op  out  1  one-cycle pulse on accepting opcode 9-15.

Function
REQ-018 FSM states IDLE, MUL_BUSY; in_ready = 1 only in IDLE.
REQ-019 IDLE, accept of op 0-7: result registered on accept edge; reg_write = wb_en for exactly the following cycle (latency 1); state stays IDLE.
REQ-020 Back-to-back single-cycle ops accepted every cycle; one reg_write pulse per accepted op with wb_en = 1.
REQ-021 Arithmetic modulo 2^DATA_W; SLT result 1 or 0; SLL/SRL shift src_a by src_b[4:0]; SRL logical.
REQ-022 ovf_flag: ADD sets when operand signs equal and result sign differs; SUB when operand signs differ and result sign differs from src_a.
REQ-023 Accept of MUL: IDLE -> MUL_BUSY, step counter cleared; one shift-add step per cycle in MUL_BUSY.
REQ-024 After MUL_STEPS steps (edge N+32 for accept at edge N): MUL_BUSY -> IDLE, low DATA_W bits of product registered, reg_write = wb_en for the next cycle.
REQ-025 in_valid while in_ready = 0 ignored; inputs need not be held; operands latched at accept.
REQ-026 Accept of illegal opcode: no reg_write, illegal_op high one cycle, write_data and flags unchanged.
REQ-027 wb_en = 0: result, zero_flag, ovf_flag still updated; reg_write stays 0.
REQ-028 write_reg_num and write_data hold their values until next completed operation.
REQ-029 dest_reg 0 not special; written like any register.

Reset
REQ-030 rst = 0 at edge: state IDLE, counter 0, reg_write 0, illegal_op 0, write_data 0, write_reg_num 0, zero_flag 0, ovf_flag 0.
REQ-031 rst during MUL_BUSY aborts multiply; no reg_write issued for it.
REQ-032 rst asserted with in_valid: nothing accepted; in_ready = 1 from first cycle after release.

Structure
REQ-033 Package alu_exec_pkg holds opcode enum, FSM state enum, DATA_W default.
REQ-034 Sub-module shift_add_multiplier holds MUL datapath (multiplicand, multiplier, accumulator, step counter, start/done).
REQ-035 All other logic within alu_exec_stage; no latches, no asynchronous logic.

Verification
REQ-036 ADD 0x7FFFFFFF + 0x00000001, dest 5, wb_en 1 -> next cycle reg_write 1, write_reg_num 5, write_data 0x80000000, ovf_flag 1, zero_flag 0.
REQ-037 SUB 3 - 3 then SLT 0xFFFFFFFF vs 1 back-to-back -> write_data 0 with zero_flag 1, then write_data 1; two reg_write pulses on consecutive cycles.
REQ-038 MUL 0x00010001 x 0x00010001, dest 7 -> in_ready low 32 cycles, write_data 0x00020001 one cycle after return to IDLE; in_valid pulses while busy produce no writes.
REQ-039 MUL 6 x 7 with rst = 0 at cycle 10 of busy -> no reg_write, all outputs 0, in_ready 1 after release.
REQ-040 op 12 -> illegal_op pulse 1 cycle, reg_write 0, write_data unchanged; SRL 0x80000000 by 31 with wb_en 0 -> write_data 1, reg_write 0.
